// File: rtl/stch_pkg.sv
// Shared definitions for the stochastic-to-decimal window converter.
package stch_pkg;
    localparam int ND_DEF = 8;
    localparam int W      = 1 << ND_DEF;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;
endpackage

// File: rtl/stch_ones_cnt.sv
// Ones counter (ND+1 bits) plus window counter; flags the last sample of a 2^ND window.
module stch_ones_cnt
    import stch_pkg::*;
#(
    parameter int ND = ND_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic        i_s,
    output logic [ND:0] o_ones_next,
    output logic        o_last
);
    logic [ND:0]   r_ones;
    logic [ND-1:0] r_win;

    // The last sample is folded into the result combinationally, so the count
    // presented at the window-end edge already includes it.
    assign o_ones_next = r_ones + {{ND{1'b0}}, i_s};
    assign o_last      = i_en && (r_win == {ND{1'b1}});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ones <= '0;
            r_win  <= '0;
        end else if (i_clr) begin
            r_ones <= '0;
            r_win  <= '0;
        end else if (i_en) begin
            r_ones <= o_ones_next;
            r_win  <= r_win + 1'b1;
        end
    end
endmodule

// File: rtl/stch2dec_window.sv
// Converts a stochastic bit stream to an ND-bit value over a 2^ND-cycle window, with a
// VALID/READY output register. Define STCH2DEC_BIPOLAR_EN for a two's-complement bipolar result.
module stch2dec_window
    import stch_pkg::*;
#(
    parameter int ND = ND_DEF
) (
    input  logic          i_clk,
    input  logic          i_init_n,
    input  logic          i_start,
    input  logic          i_cont,
    input  logic          i_s,
    input  logic          i_ready,
    output logic [ND-1:0] o_d_out,
    output logic          o_valid,
    output logic          o_ovf,
    output logic          o_busy
);
    state_t        r_state, w_state_nxt;
    logic          w_en, w_clr, w_last;
    logic [ND:0]   w_ones_next;
    logic [ND-1:0] w_sat;
    logic [ND-1:0] r_d_out;
    logic          r_valid, r_ovf;

    assign w_en = (r_state == ACCUM);

    stch_ones_cnt #(.ND(ND)) u_cnt (
        .i_clk       (i_clk),
        .i_rst_n     (i_init_n),
        .i_clr       (w_clr),
        .i_en        (w_en),
        .i_s         (i_s),
        .o_ones_next (w_ones_next),
        .o_last      (w_last)
    );

`ifdef STCH2DEC_BIPOLAR_EN
    // ones - 2^(ND-1) for ones < 2^ND is just an MSB flip; a full window clamps to max positive.
    assign w_sat = w_ones_next[ND] ? {1'b0, {(ND-1){1'b1}}}
                                   : {~w_ones_next[ND-1], w_ones_next[ND-2:0]};
`else
    assign w_sat = w_ones_next[ND] ? {ND{1'b1}} : w_ones_next[ND-1:0];
`endif

    always_ff @(posedge i_clk or negedge i_init_n) begin
        if (!i_init_n) r_state <= IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = ACCUM;
                    w_clr       = 1'b1;
                end
            end
            ACCUM: begin
                if (w_last) begin
                    w_state_nxt = i_cont ? ACCUM : IDLE;
                    w_clr       = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A new result always wins over a same-edge READY, so back-to-back windows never bubble.
    always_ff @(posedge i_clk or negedge i_init_n) begin
        if (!i_init_n) begin
            r_d_out <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_last) begin
            r_d_out <= w_sat;
            r_valid <= 1'b1;
            if (r_valid && !i_ready) r_ovf <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_d_out = r_d_out;
    assign o_valid = r_valid;
    assign o_ovf   = r_ovf;
    assign o_busy  = w_en;
endmodule

// File: tb/tb_stch2dec_window.sv
// Directed bench for stch2dec_window (ND=8); expectations follow STCH2DEC_BIPOLAR_EN when defined.
module tb_stch2dec_window;
    logic       clk = 1'b0;
    logic       init_n, start, cont, s, ready;
    logic [7:0] d_out;
    logic       valid, ovf, busy;
    int         total = 0;
    int         bad   = 0;
    logic [7:0] lfsr;

`ifdef STCH2DEC_BIPOLAR_EN
    localparam logic [7:0] E_ALL1 = 8'h7F, E_ALL0 = 8'h80, E_ALT = 8'h00, E_Q = 8'hC0,
                           E_100  = 8'hE4, E_255  = 8'h7F, E_ONE = 8'h81, E_LFSR = 8'hC0;
`else
    localparam logic [7:0] E_ALL1 = 8'd255, E_ALL0 = 8'd0, E_ALT = 8'd128, E_Q = 8'd64,
                           E_100  = 8'd100, E_255  = 8'd255, E_ONE = 8'd1, E_LFSR = 8'd64;
`endif

    typedef struct {
        int         mode;
        logic [7:0] exp_d;
        string      name;
    } vec_t;

    stch2dec_window #(.ND(8)) dut (
        .i_clk    (clk),
        .i_init_n (init_n),
        .i_start  (start),
        .i_cont   (cont),
        .i_s      (s),
        .i_ready  (ready),
        .o_d_out  (d_out),
        .o_valid  (valid),
        .o_ovf    (ovf),
        .o_busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // modes: 0 zeros, 1 ones, 2 alternating, 3 every 4th, 4 first 100, 5 first 255, 6 only first, 7 LFSR<64
    function automatic logic pat(input int mode, input int k);
        case (mode)
            0: return 1'b0;
            1: return 1'b1;
            2: return k[0];
            3: return (k % 4) == 0;
            4: return k < 100;
            5: return k < 255;
            6: return k == 0;
            default: return 1'b0;
        endcase
    endfunction

    // Drive samples k in [lo, hi], one per edge.
    task automatic feed(input int mode, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            if (mode == 7) begin
                if (k == 0) lfsr = 8'd1;
                else        lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                s = (lfsr < 8'd64);
            end else begin
                s = pat(mode, k);
            end
            tick();
        end
    endtask

    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        init_n = 1'b0;
        #3;
        init_n = 1'b1;
        tick();
    endtask

    vec_t vt[8];

    initial begin
        vt[0] = '{1, E_ALL1, "all_ones_sat"};
        vt[1] = '{0, E_ALL0, "all_zeros"};
        vt[2] = '{2, E_ALT,  "alternating"};
        vt[3] = '{3, E_Q,    "quarter"};
        vt[4] = '{4, E_100,  "first100"};
        vt[5] = '{5, E_255,  "first255"};
        vt[6] = '{6, E_ONE,  "single_one"};
        vt[7] = '{7, E_LFSR, "lfsr_d64"};

        start = 0; cont = 0; s = 0; ready = 0; init_n = 1;
        #2;
        init_n = 0;
        #10;
        chk("reset_d", d_out, 8'd0);
        chk("reset_valid", valid, 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_busy", busy, 0);
        init_n = 1;
        tick();

        for (int i = 0; i < 8; i++) begin
            kick();
            chk({vt[i].name, "_busy"}, busy, 1);
            feed(vt[i].mode, 0, 254);
            chk({vt[i].name, "_early"}, valid, 0);
            feed(vt[i].mode, 255, 255);
            chk({vt[i].name, "_valid"}, valid, 1);
            chk({vt[i].name, "_d"}, d_out, vt[i].exp_d);
            chk({vt[i].name, "_ovf"}, ovf, 0);
            chk({vt[i].name, "_idle"}, busy, 0);
            tick();
            chk({vt[i].name, "_hold"}, d_out, vt[i].exp_d);
            ready = 1;
            tick();
            ready = 0;
            chk({vt[i].name, "_consumed"}, valid, 0);
        end

        // Continuous windows: same-edge READY loads without bubble, then an unread overwrite sets OVF.
        do_reset();
        cont = 1;
        kick();
        feed(2, 0, 255);
        chk("cont_w1_d", d_out, E_ALT);
        chk("cont_w1_busy", busy, 1);
        feed(1, 0, 254);
        ready = 1;
        feed(1, 255, 255);
        ready = 0;
        chk("cont_w2_valid", valid, 1);
        chk("cont_w2_d", d_out, E_ALL1);
        chk("cont_w2_ovf", ovf, 0);
        feed(0, 0, 200);
        cont = 0;
        feed(0, 201, 255);
        chk("cont_w3_d", d_out, E_ALL0);
        chk("cont_w3_valid", valid, 1);
        chk("cont_w3_ovf", ovf, 1);
        chk("cont_w3_idle", busy, 0);
        ready = 1;
        tick();
        ready = 0;
        chk("ovf_sticky", ovf, 1);

        // Reset mid-window discards the partial count; START inside ACCUM is ignored.
        do_reset();
        kick();
        feed(1, 0, 99);
        init_n = 0;
        #2;
        chk("midrst_d", d_out, 8'd0);
        chk("midrst_valid", valid, 0);
        chk("midrst_ovf", ovf, 0);
        chk("midrst_busy", busy, 0);
        init_n = 1;
        tick();
        tick();
        chk("midrst_no_result", valid, 0);
        kick();
        feed(4, 0, 49);
        start = 1;
        feed(4, 50, 50);
        start = 0;
        feed(4, 51, 254);
        chk("restart_early", valid, 0);
        feed(4, 255, 255);
        chk("restart_valid", valid, 1);
        chk("restart_d", d_out, E_100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
